heap_port_arbiter: RTL and testbench
====================================

Name: heap_port_arbiter

Overview:
- Shares the GPU-side read/write port (port B) of the heap memory among NUM_REQ GPU requesters, e.g. shader lanes, rasterizer or DMA.
- Arbitration is round-robin with one grant per clock.
- Each granted transaction is tracked through the synchronous-read memory pipeline, and its response is routed back to the originating requester.
- Sits between the GPU cores and the heap memory port B; the CPU write port (port A) is not touched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width
WORD_BYTES, 4, byte-enable width (DATA_WIDTH/8)
READ_LATENCY, 1, clocks from address presented to mem_rd_data valid (1..4)

Ports:
clk  input  1  single clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester transaction request
req_ready  output  NUM_REQ  one-hot grant; transaction accepted when valid&ready
req_addr  input  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at slice i
req_wr_data  input  NUM_REQ*DATA_WIDTH  packed write data
req_wr_en  input  NUM_REQ*WORD_BYTES  packed byte enables; all-zero = read
rsp_valid  output  NUM_REQ  one-hot; response for requester i this cycle
rsp_data  output  DATA_WIDTH  read data, shared by all requesters and qualified by rsp_valid
mem_address  output  ADDR_WIDTH  to heap port_b_address
mem_wr_data  output  DATA_WIDTH  to heap port_b_wr_data
mem_wr_en  output  WORD_BYTES  to heap port_b_wr_en
mem_rd_data  input  DATA_WIDTH  from heap port_b_rd_data

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - rr_ptr <= 0.
  - The in-flight pipeline is cleared, and responses in flight are dropped without ever asserting rsp_valid.
  - While reset_n=0, the following are forced to 0: req_ready, rsp_valid, mem_wr_en, mem_address, mem_wr_data.
- Arbitration (combinational in the same cycle):
  - Scan requesters rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first with req_valid=1 is the winner g, and req_ready[g]=1; all other req_ready bits are 0.
  - With no requests, req_ready=0 and mem_wr_en=0.
- Memory drive:
  - On a grant, mem_address/mem_wr_data/mem_wr_en are driven from slice g in the same cycle.
  - With no grant, mem_wr_en=0 and the address holds its last value.
- Pointer update: on an accepted grant, rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no grant, rr_ptr is unchanged.
- Tracking pipeline:
  - A shift register of depth READ_LATENCY carries {valid, g}.
  - A transaction accepted at cycle T asserts rsp_valid[g]=1 exactly at cycle T+READ_LATENCY.
  - At that cycle, rsp_data = mem_rd_data (registered version not required).
- Writes also produce rsp_valid (acknowledge); rsp_data is don't-care for pure writes.
- Throughput: one transaction per clock sustained, with no bubbles between back-to-back grants.
- Ordering:
  - Responses are returned in acceptance order.
  - A requester may issue back-to-back transactions when it keeps winning; with N active requesters, each gets 1 of every N slots.
- Starvation bound: a requester holding req_valid is granted within NUM_REQ cycles.
- req_valid must stay asserted until req_ready; withdrawal before grant is allowed but carries no guarantee. Request payload must be stable while req_valid=1.
- Reset mid-operation: reset behaviour as above; the first grant after reset_n rises goes to the lowest-indexed valid requester.

Optional Feature:
- Macro: HEAP_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock (NUM_REQ bits).
  - A grant accepted with req_lock[g]=1 sets lock_owner=g and locked=1.
  - While locked, only lock_owner is eligible; others see req_ready=0 even with the memory idle.
  - An accepted owner transaction with req_lock[g]=0 clears locked at the next edge.
  - rr_ptr is updated normally on owner grants.
  - Reset clears locked.
  - This enables atomic read-modify-write on the heap.
- When undefined: no req_lock port; pure round-robin.

Test Plan:
- Single read: requester 2 issues a read of 0x100 (mem returns 0xDEADBEEF) -> req_ready[2]=1 same cycle; rsp_valid=4'b0100 and rsp_data=0xDEADBEEF exactly READ_LATENCY cycles later.
- All 4 requesters valid continuously for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; mem_address tracks the winner each cycle; 8 responses in the same order.
- Requesters 1 and 3 valid, rr_ptr=2 -> 3 granted first, then 1; pointer wraps 3->0 correctly.
- Requester 0 writes 0xCAFEF00D with wr_en=4'b0011 to 0x40 -> mem_wr_en=4'b0011 for exactly one cycle; ack rsp_valid[0] at T+READ_LATENCY.
- Accept a read, then drop reset_n before the response -> no rsp_valid ever fires for it; outputs are 0 during reset; the first post-reset grant goes to the lowest valid index.
- With HEAP_ARB_LOCK_EN defined: requester 1 reads with lock=1 while 0 and 2 are valid -> only 1 is granted until its write with lock=0; round-robin then resumes at 2.

Source files
------------

// File: rtl/heap_port_arbiter.sv
// -----------------------------------------------------------------------------
// heap_port_arbiter
//
// Purpose:
//   Shares the GPU-side read/write port (port B) of the heap memory among
//   NUM_REQ requesters. One round-robin grant per clock. Each accepted
//   transaction is tracked through the synchronous-read memory pipeline so
//   that its response (read data or write acknowledge) is steered back to
//   the requester that issued it, exactly READ_LATENCY clocks after
//   acceptance and in acceptance order.
//
// Optional feature (compile-time macro HEAP_ARB_LOCK_EN):
//   Adds req_lock. A grant taken with req_lock[g]=1 locks the port to g until
//   g completes a transaction with req_lock[g]=0 (atomic read-modify-write).
//   Without the macro the arbiter is pure round-robin and has no req_lock.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      synchronous active-low reset
//   req_valid    per-requester request
//   req_ready    one-hot grant (accept on valid & ready)
//   req_addr     packed byte addresses, requester i at slice i
//   req_wr_data  packed write data
//   req_wr_en    packed byte enables, all-zero = read
//   req_lock     (HEAP_ARB_LOCK_EN only) per-requester lock request
//   rsp_valid    one-hot response strobe
//   rsp_data     shared read data, qualified by rsp_valid
//   mem_address  heap port B address
//   mem_wr_data  heap port B write data
//   mem_wr_en    heap port B byte write enables
//   mem_rd_data  heap port B read data
// -----------------------------------------------------------------------------
module heap_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int WORD_BYTES   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
  input  logic [NUM_REQ*WORD_BYTES-1:0]    req_wr_en,
`ifdef HEAP_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock,
`endif
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wr_data,
  output logic [WORD_BYTES-1:0]            mem_wr_en,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;

  logic [NUM_REQ-1:0]    w_eligible;
  logic [2*NUM_REQ-1:0]  w_rot;
  logic [PTR_W-1:0]      w_ofs;
  logic [PTR_W:0]        w_sum;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
  logic [WORD_BYTES-1:0] w_be_arr    [NUM_REQ];

  logic [READ_LATENCY-1:0] r_trk_vld_p;
  logic [PTR_W-1:0]        r_trk_id_p [READ_LATENCY];

`ifdef HEAP_ARB_LOCK_EN
  logic             r_locked;
  logic [PTR_W-1:0] r_lock_owner;
`endif

  // Unpack the flat request buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata_arr[i] = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_be_arr[i]    = req_wr_en[i*WORD_BYTES +: WORD_BYTES];
    end
  end

  // Requesters allowed to compete this cycle. Reset masks everyone so
  // req_ready and the memory strobes fall to zero without extra gating.
  always_comb begin
    w_eligible = reset_n ? req_valid : '0;
`ifdef HEAP_ARB_LOCK_EN
    if (r_locked) begin
      w_eligible = w_eligible & (NUM_REQ'(1) << r_lock_owner);
    end
`endif
  end

  // Round-robin search: rotate the eligible vector so rr_ptr lands on bit 0,
  // take the first set bit, then translate the offset back modulo NUM_REQ.
  always_comb begin
    w_rot     = {w_eligible, w_eligible} >> r_rr_ptr;
    w_gnt_any = 1'b0;
    w_ofs     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_any && w_rot[k]) begin
        w_gnt_any = 1'b1;
        w_ofs     = PTR_W'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
    if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
    end
    w_gnt_idx = w_sum[PTR_W-1:0];
  end

  always_comb begin
    req_ready   = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    mem_wr_en   = w_gnt_any ? w_be_arr[w_gnt_idx] : '0;
    mem_address = !reset_n ? '0 : (w_gnt_any ? w_addr_arr[w_gnt_idx]  : r_addr_hold);
    mem_wr_data = !reset_n ? '0 : (w_gnt_any ? w_wdata_arr[w_gnt_idx] : r_wdata_hold);
  end

  // ---- Stage p0: grant accepted, pointer / hold registers advance ----------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr     <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr     <= (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
      r_addr_hold  <= w_addr_arr[w_gnt_idx];
      r_wdata_hold <= w_wdata_arr[w_gnt_idx];
    end
  end

`ifdef HEAP_ARB_LOCK_EN
  // Every accepted grant can only come from the owner while locked, so the
  // lock state simply follows req_lock of whoever was last granted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_locked <= 1'b0;
    end else if (w_gnt_any) begin
      r_locked <= req_lock[w_gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_any) begin
      r_lock_owner <= w_gnt_idx;
    end
  end
`endif

  // ---- Stages p0..pN-1: tracking pipeline aligned with memory read latency --
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_trk_vld_p <= '0;
    end else begin
      r_trk_vld_p[0] <= w_gnt_any;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_trk_vld_p[i] <= r_trk_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_trk_id_p[0] <= w_gnt_idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_trk_id_p[i] <= r_trk_id_p[i-1];
    end
  end

  // ---- Response stage: last tracking entry lines up with mem_rd_data -------
  always_comb begin
    rsp_valid = (reset_n && r_trk_vld_p[READ_LATENCY-1])
              ? (NUM_REQ'(1) << r_trk_id_p[READ_LATENCY-1]) : '0;
    rsp_data  = mem_rd_data;
  end

endmodule

// File: tb/tb_heap_port_arbiter.sv
`timescale 1ns/1ps
module tb_heap_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WB = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wr_data;
  logic [N*WB-1:0]   req_wr_en;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_wr_data;
  logic [WB-1:0]     mem_wr_en;
  logic [DW-1:0]     mem_rd_data;
`ifdef HEAP_ARB_LOCK_EN
  logic [N-1:0]      req_lock;
  logic              a_lock [N];
`endif

  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_data [N];
  logic [WB-1:0] a_we   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = a_addr[i];
      req_wr_data[i*DW +: DW] = a_data[i];
      req_wr_en[i*WB +: WB]   = a_we[i];
`ifdef HEAP_ARB_LOCK_EN
      req_lock[i]             = a_lock[i];
`endif
    end
  end

  heap_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_BYTES(WB), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_wr_en(req_wr_en),
`ifdef HEAP_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [WB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < WB; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---------------- heap memory port B model (synchronous read) ------------
  logic [DW-1:0] hw_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [RL];
  assign mem_rd_data = rd_pipe[RL-1];

  always @(posedge clk) begin
    logic [DW-1:0] cur;
    cur = hw_mem.exists(mem_address) ? hw_mem[mem_address] : dflt(mem_address);
    rd_pipe[0] <= cur;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr_en != '0) hw_mem[mem_address] = merge(cur, mem_wr_data, mem_wr_en);
  end

  // ---------------- reference model and scoreboard --------------------------
  typedef struct {
    int            id;
    bit            rd;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            mptr    = 0;
  bit            hold_vld = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [N-1:0]  acc_q = '0;
`ifdef HEAP_ARB_LOCK_EN
  bit            mlocked = 1'b0;
  int            mowner  = 0;
`endif

  // Grant side: predict the winner from the round-robin rule, check the
  // port-B drive, and enqueue the response the requester should receive.
  always @(negedge clk) if (run) begin
    if (!reset_n) begin
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      chk("wren_in_reset",  64'(mem_wr_en), 64'(0));
      chk("addr_in_reset",  64'(mem_address), 64'(0));
      chk("wdata_in_reset", 64'(mem_wr_data), 64'(0));
      mptr = 0; hold_vld = 1'b0; acc_q = '0;
      sbq.delete();
`ifdef HEAP_ARB_LOCK_EN
      mlocked = 1'b0;
`endif
    end else begin
      int win;
      int idx;
      logic [N-1:0] er;
      exp_t e;
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
`ifdef HEAP_ARB_LOCK_EN
        if (win < 0 && req_valid[idx] && (!mlocked || idx == mowner)) win = idx;
`else
        if (win < 0 && req_valid[idx]) win = idx;
`endif
      end
      er = (win >= 0) ? (N'(1) << win) : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      acc_q = req_valid & req_ready;
      if (win >= 0) begin
        chk("mem_address", 64'(mem_address), 64'(a_addr[win]));
        chk("mem_wr_en",   64'(mem_wr_en),   64'(a_we[win]));
        if (a_we[win] != '0) chk("mem_wr_data", 64'(mem_wr_data), 64'(a_data[win]));
        e.id  = win;
        e.rd  = (a_we[win] == '0);
        e.due = cyc + RL;
        e.data = ref_mem.exists(a_addr[win]) ? ref_mem[a_addr[win]] : dflt(a_addr[win]);
        if (!e.rd) ref_mem[a_addr[win]] = merge(e.data, a_data[win], a_we[win]);
        sbq.push_back(e);
        mptr = (win + 1) % N;
        hold_vld = 1'b1;
        hold_addr = a_addr[win];
`ifdef HEAP_ARB_LOCK_EN
        mlocked = a_lock[win];
        mowner  = win;
`endif
      end else begin
        chk("wren_idle", 64'(mem_wr_en), 64'(0));
        if (hold_vld) chk("addr_hold", 64'(mem_address), 64'(hold_addr));
      end
    end
  end

  // Response side: pops the scoreboard whenever a response is due.
  always @(negedge clk) if (run) begin
    if (!reset_n) begin
      chk("rsp_in_reset", 64'(rsp_valid), 64'(0));
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.id));
      if (e.rd) chk("rsp_data", 64'(rsp_data), 64'(e.data));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'(0));
    end
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                         input logic [WB-1:0] we);
    req_valid[i] = 1'b1;
    a_addr[i] = ad;
    a_data[i] = d;
    a_we[i]   = we;
`ifdef HEAP_ARB_LOCK_EN
    a_lock[i] = 1'b0;
`endif
  endtask

  task automatic new_req(input int i, input int p);
    if (int'($urandom_range(0, 99)) < p) begin
      set_req(i, AW'($urandom_range(0, 15)) << 2, $urandom,
              ($urandom_range(0, 1) == 1) ? WB'($urandom_range(1, 15)) : '0);
`ifdef HEAP_ARB_LOCK_EN
      a_lock[i] = ($urandom_range(0, 4) == 0);
`endif
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  // Replace accepted (or idle) requests; ungranted ones stay asserted.
  task automatic step(input int p);
    for (int i = 0; i < N; i++) if (acc_q[i] || !req_valid[i]) new_req(i, p);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      step(0);
`ifdef HEAP_ARB_LOCK_EN
      if (mlocked && !req_valid[mowner]) set_req(mowner, '0, '0, '0);
`endif
      if (req_valid == '0 && sbq.size() == 0) done = 1'b1;
    end
    chk("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0; a_data[i] = '0; a_we[i] = '0;
`ifdef HEAP_ARB_LOCK_EN
      a_lock[i] = 1'b0;
`endif
    end
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    // Everyone requesting while reset is held: all outputs must stay zero.
    for (int i = 0; i < N; i++) set_req(i, AW'(i*4), $urandom, WB'(4'hF));
    run = 1'b1;
    repeat (3) tick();

    // All four valid continuously for 8 cycles: grants 0,1,2,3,0,1,2,3.
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      step(100);
    end
    drain();

    // Single read by requester 2.
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    hw_mem[32'h100]  = 32'hDEAD_BEEF;
    set_req(2, 32'h100, '0, '0);
    drain();

    // Partial write by requester 0, then read it back through requester 3.
    set_req(0, 32'h40, 32'hCAFE_F00D, 4'b0011);
    drain();
    set_req(3, 32'h40, '0, '0);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      tick();
      step(45);
    end
    drain();

    // Reset while a read is in flight; 1 and 3 waiting across the reset.
    set_req(1, 32'h8, '0, '0);
    tick();
    reset_n = 1'b0;
    set_req(1, 32'h10, '0, '0);
    set_req(3, 32'h14, '0, '0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();            // requester 1 wins first after reset, pointer -> 2
    step(0);
    set_req(1, 32'h18, '0, '0);   // now 3 must precede 1, pointer wraps
    drain();

`ifdef HEAP_ARB_LOCK_EN
    // Requester 1 takes a lock; 0 and 2 must wait until it unlocks.
    set_req(1, 32'h20, '0, '0);
    a_lock[1] = 1'b1;
    tick();
    step(0);
    set_req(0, 32'h24, '0, '0);
    set_req(2, 32'h28, '0, '0);
    set_req(1, 32'h20, '0, '0);
    a_lock[1] = 1'b1;
    tick();
    step(0);
    set_req(1, 32'h20, 32'h1234_5678, 4'hF);
    tick();
    step(0);
    drain();
`endif

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
